// File: rtl/cellram_pkg.sv
// Shared constants, state encoding and LFSR step function for the cellram BIST.
package cellram_pkg;

    localparam int Nb        = 16;
    localparam int Nb_addr   = 23;
    localparam int Nb_bl     = 6;
    localparam int Nb_inst   = 3;
    localparam int MAX_WORDS = 1 << Nb_bl;

    localparam logic [Nb_inst-1:0] INSTR_WRITE = 3'b000;
    localparam logic [Nb_inst-1:0] INSTR_READ  = 3'b001;

    localparam logic [Nb-1:0] LFSR_MASK      = 16'hB400;
    localparam logic [Nb-1:0] LFSR_ZERO_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_WR_CMD,
        S_RD_CMD,
        S_RD_DATA,
        S_DONE
    } state_t;

    // Galois right-shift step; the mask is folded in when the bit shifted out is 1.
    function automatic logic [Nb-1:0] lfsr_next(input logic [Nb-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/cellram_bist_lfsr.sv
// Pattern generator: loads a (zero-substituted) seed, steps only when told to.
module cellram_bist_lfsr
    import cellram_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          advance,
    input  logic [Nb-1:0] seed,
    output logic [Nb-1:0] state
);

    // Load has priority so a new test always restarts the sequence cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= '0;
        else if (load)
            state <= (seed == '0) ? LFSR_ZERO_SEED : seed;
        else if (advance)
            state <= lfsr_next(state);
    end

endmodule

// File: rtl/cellram_bist.sv
// Write/read-back self test for the cellram user port.
// Optional watchdog: define CELLRAM_BIST_TIMEOUT_EN to add the timeout output.
module cellram_bist
    import cellram_pkg::*;
(
    input  logic               clk_core,
    input  logic               reset,
    input  logic               start,
    input  logic [Nb_addr-1:0] base_addr,
    input  logic [Nb_bl:0]     num_words,
    input  logic [Nb-1:0]      seed,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               bad_len,
    output logic [Nb_bl:0]     err_count,
    output logic [Nb_bl-1:0]   first_err,
`ifdef CELLRAM_BIST_TIMEOUT_EN
    output logic               timeout,
`endif
    output logic [Nb_bl-1:0]   cmd_bl,
    output logic [Nb_inst-1:0] cmd_instr,
    output logic [Nb_addr-1:0] cmd_addr,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [Nb-1:0]      wr_data,
    output logic               wr_valid,
    input  logic               wr_ready,
    input  logic [Nb-1:0]      rd_data,
    input  logic               rd_valid,
    output logic               rd_ready
);

    state_t          st;
    logic [Nb_bl:0]  n_words;
    logic [Nb_bl:0]  cnt;
    logic [Nb-1:0]   cmp_word;
    logic            start_ok, wr_fire, cmd_fire, rd_fire, mismatch, last;

`ifdef CELLRAM_BIST_TIMEOUT_EN
    logic [15:0]     wdog;
`endif

    assign start_ok = start && (st == S_IDLE);
    assign wr_fire  = wr_valid && wr_ready;
    assign cmd_fire = cmd_valid && cmd_ready;
    assign rd_fire  = rd_valid && rd_ready;
    assign mismatch = (rd_data != cmp_word);
    assign last     = (cnt == n_words - 1'b1);

    // Both generators restart from the same seed; wr_data is the write LFSR register itself.
    cellram_bist_lfsr u_wr_lfsr (
        .clk(clk_core), .reset(reset), .load(start_ok), .advance(wr_fire),
        .seed(seed), .state(wr_data)
    );

    cellram_bist_lfsr u_cmp_lfsr (
        .clk(clk_core), .reset(reset), .load(start_ok), .advance(rd_fire),
        .seed(seed), .state(cmp_word)
    );

    // Test sequencer: write burst, write cmd, read cmd, read-back compare, report.
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            st        <= S_IDLE;
            n_words   <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            bad_len   <= 1'b0;
            err_count <= '0;
            first_err <= '0;
            cmd_bl    <= '0;
            cmd_instr <= '0;
            cmd_addr  <= '0;
            cmd_valid <= 1'b0;
            wr_valid  <= 1'b0;
            rd_ready  <= 1'b0;
`ifdef CELLRAM_BIST_TIMEOUT_EN
            timeout   <= 1'b0;
            wdog      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (st)
                S_IDLE: if (start) begin
                    err_count <= '0;
                    first_err <= '0;
                    bad_len   <= 1'b0;
                    pass      <= 1'b0;
`ifdef CELLRAM_BIST_TIMEOUT_EN
                    timeout   <= 1'b0;
`endif
                    if (num_words == '0) begin
                        done <= 1'b1;
                        pass <= 1'b1;
                    end else if (num_words > (Nb_bl+1)'(MAX_WORDS)) begin
                        done    <= 1'b1;
                        bad_len <= 1'b1;
                    end else begin
                        n_words  <= num_words;
                        cmd_addr <= base_addr;
                        cmd_bl   <= Nb_bl'(num_words - 1'b1);
                        cnt      <= '0;
                        busy     <= 1'b1;
                        wr_valid <= 1'b1;
                        st       <= S_WR_DATA;
                    end
                end
                S_WR_DATA: if (wr_fire) begin
                    if (last) begin
                        cnt       <= '0;
                        wr_valid  <= 1'b0;
                        cmd_valid <= 1'b1;
                        cmd_instr <= INSTR_WRITE;
                        st        <= S_WR_CMD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WR_CMD: if (cmd_fire) begin
                    cmd_instr <= INSTR_READ;
                    st        <= S_RD_CMD;
                end
                S_RD_CMD: if (cmd_fire) begin
                    cmd_valid <= 1'b0;
                    rd_ready  <= 1'b1;
                    st        <= S_RD_DATA;
                end
                S_RD_DATA: if (rd_fire) begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (err_count == '0)
                            first_err <= cnt[Nb_bl-1:0];
                    end
                    if (last) begin
                        // done is raised while still busy so a coincident start is ignored.
                        rd_ready <= 1'b0;
                        done     <= 1'b1;
                        pass     <= (err_count == '0) && !mismatch;
                        st       <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                    st   <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
`ifdef CELLRAM_BIST_TIMEOUT_EN
            // Watchdog overrides the sequencer when no handshake has happened for 64K cycles.
            if (st == S_IDLE || st == S_DONE) begin
                wdog <= '0;
            end else if (wr_fire || cmd_fire || rd_fire) begin
                wdog <= '0;
            end else if (wdog == 16'hFFFF) begin
                wdog      <= '0;
                wr_valid  <= 1'b0;
                cmd_valid <= 1'b0;
                rd_ready  <= 1'b0;
                done      <= 1'b1;
                pass      <= 1'b0;
                timeout   <= 1'b1;
                st        <= S_DONE;
            end else begin
                wdog <= wdog + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_cellram_bist.sv
// Bench: memory-backed responder with random stalls and read corruption, checked
// against an LFSR pattern model derived from the published polynomial.
module tb_cellram_bist;
    import cellram_pkg::*;

    logic        clk_core = 1'b0;
    logic        reset, start;
    logic [22:0] base_addr;
    logic [6:0]  num_words;
    logic [15:0] seed;
    logic        busy, done, pass, bad_len;
    logic [6:0]  err_count;
    logic [5:0]  first_err, cmd_bl;
    logic [2:0]  cmd_instr;
    logic [22:0] cmd_addr;
    logic        cmd_valid, cmd_ready;
    logic [15:0] wr_data, rd_data;
    logic        wr_valid, wr_ready, rd_valid, rd_ready;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [int];
    bit          r_done;
    int          r_wr, r_cmd, r_rd;
    logic        r_pass;
    logic [6:0]  r_err;
    logic [5:0]  r_first;

    always #5 clk_core = ~clk_core;

    cellram_bist dut (
        .clk_core(clk_core), .reset(reset), .start(start), .base_addr(base_addr),
        .num_words(num_words), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .bad_len(bad_len), .err_count(err_count), .first_err(first_err),
        .cmd_bl(cmd_bl), .cmd_instr(cmd_instr), .cmd_addr(cmd_addr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready)
    );

    function automatic logic [15:0] step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int exp_errs(input logic [63:0] c, input int n);
        int k = 0;
        for (int i = 0; i < n; i++) if (c[i]) k++;
        return k;
    endfunction

    function automatic int exp_first(input logic [63:0] c, input int n);
        for (int i = 0; i < n; i++) if (c[i]) return i;
        return 0;
    endfunction

    // Drive one test through the handshakes; abort_at >= 0 pulls reset at that read index.
    task automatic run_bist(input logic [22:0] addr, input int n, input logic [15:0] sd,
                            input bit stall, input logic [63:0] corrupt, input int abort_at);
        logic [15:0] wq[$];
        logic [15:0] rq[$];
        logic [15:0] s, pw_data;
        logic [2:0]  pc_instr;
        logic [22:0] pc_addr;
        logic [5:0]  pc_bl;
        bit          pw = 0, pc = 0, rp = 0;
        int          ri = 0;
        s = (sd == 16'h0) ? 16'hACE1 : sd;
        r_done = 0; r_wr = 0; r_cmd = 0; r_rd = 0;
        @(negedge clk_core);
        base_addr = addr; num_words = 7'(n); seed = sd; start = 1'b1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk_core);
            start = 1'b0;
            if (pw) begin
                vectors++;
                if (wr_valid !== 1'b1 || wr_data !== pw_data) begin
                    miscompares++;
                    $display("FAIL wr_stable: got v=%b d=%h expected v=1 d=%h", wr_valid, wr_data, pw_data);
                end
            end
            if (pc) begin
                vectors++;
                if (cmd_valid !== 1'b1 || {cmd_instr, cmd_addr, cmd_bl} !== {pc_instr, pc_addr, pc_bl}) begin
                    miscompares++;
                    $display("FAIL cmd_stable: got v=%b %h/%h/%h expected %h/%h/%h",
                             cmd_valid, cmd_instr, cmd_addr, cmd_bl, pc_instr, pc_addr, pc_bl);
                end
            end
            if (done === 1'b1) begin
                r_done = 1; r_pass = pass; r_err = err_count; r_first = first_err;
                break;
            end
            if (abort_at >= 0 && ri == abort_at && rd_ready === 1'b1) begin
                reset = 1'b1;
                #1;
                vectors++;
                if ({busy, done, pass, bad_len, cmd_valid, wr_valid, rd_ready, err_count,
                     first_err, cmd_bl, cmd_instr, cmd_addr, wr_data} !== '0) begin
                    miscompares++;
                    $display("FAIL reset_mid: busy=%b cv=%b wv=%b rr=%b err=%0d wr_data=%h expected all zero",
                             busy, cmd_valid, wr_valid, rd_ready, err_count, wr_data);
                end
                @(negedge clk_core);
                reset = 1'b0; rd_valid = 1'b0;
                r_done = 1;
                break;
            end
            wr_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            cmd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!rp) begin
                if (rq.size() > 0) begin
                    rd_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                    rd_data  = rq[0] ^ {15'h0, corrupt[ri]};
                end else begin
                    rd_valid = 1'b0;
                end
            end
            if (wr_valid && wr_ready) begin
                vectors++;
                if (wr_data !== s) begin
                    miscompares++;
                    $display("FAIL wr_pattern[%0d]: got %h expected %h", r_wr, wr_data, s);
                end
                wq.push_back(wr_data);
                s = step(s);
                r_wr++;
            end
            if (cmd_valid && cmd_ready) begin
                r_cmd++;
                vectors++;
                if (cmd_instr !== ((r_cmd == 1) ? INSTR_WRITE : INSTR_READ) || cmd_addr !== addr ||
                    cmd_bl !== 6'(n - 1) || (r_cmd == 1 && wq.size() != n)) begin
                    miscompares++;
                    $display("FAIL cmd%0d: got %h/%h/%h after %0d words expected addr %h bl %h after %0d",
                             r_cmd, cmd_instr, cmd_addr, cmd_bl, wq.size(), addr, 6'(n - 1), n);
                end
                if (cmd_instr == INSTR_WRITE) begin
                    for (int i = 0; i < wq.size(); i++) mem[int'(addr) + i] = wq[i];
                    wq.delete();
                end else begin
                    for (int i = 0; i < n; i++)
                        rq.push_back(mem.exists(int'(addr) + i) ? mem[int'(addr) + i] : 16'hDEAD);
                end
            end
            if (rd_valid && rd_ready) begin
                void'(rq.pop_front());
                ri++;
                r_rd++;
            end
            pw = wr_valid && !wr_ready;  pw_data = wr_data;
            pc = cmd_valid && !cmd_ready;
            pc_instr = cmd_instr; pc_addr = cmd_addr; pc_bl = cmd_bl;
            rp = rd_valid && !rd_ready;
        end
        vectors++;
        if (!r_done) begin
            miscompares++;
            $display("FAIL run_timeout: got no done expected done within budget");
        end
        wr_ready = 1'b0; cmd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk_core);
        vectors++;
        if ({busy, done, pass, bad_len, cmd_valid, wr_valid, rd_ready, err_count, first_err,
             cmd_bl, cmd_instr, cmd_addr, wr_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b wv=%b cv=%b rr=%b wr_data=%h expected all zero",
                     busy, done, wr_valid, cmd_valid, rd_ready, wr_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        run_bist(23'h0, 1, 16'h1234, 0, 64'h0, -1);
        vectors++;
        if (r_wr != 1 || r_cmd != 2 || r_rd != 1 || r_pass !== 1'b1 || r_err !== 7'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single: got wr=%0d cmd=%0d rd=%0d pass=%b err=%0d busy=%b expected 1 2 1 1 0 1",
                     r_wr, r_cmd, r_rd, r_pass, r_err, busy);
        end
        @(negedge clk_core);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1) begin
            miscompares++;
            $display("FAIL done_pulse: got done=%b busy=%b pass=%b expected 0 0 1", done, busy, pass);
        end
    endtask

    task automatic test_back_to_back();
        logic [22:0] addrs [5] = '{23'h0, 23'h00A0F2, 23'h001607, 23'h00A0F5, 23'h0};
        int          lens  [5] = '{16, 22, 35, 19, 16};
        for (int t = 0; t < 5; t++) begin
            run_bist(addrs[t], lens[t], 16'($urandom), 0, 64'h0, -1);
            vectors++;
            if (r_pass !== 1'b1 || r_err !== 7'd0 || r_rd != lens[t]) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got pass=%b err=%0d rd=%0d expected 1 0 %0d", t, r_pass, r_err, r_rd, lens[t]);
            end
        end
    endtask

    task automatic test_corrupt();
        logic [63:0] c;
        int          n;
        run_bist(23'h000100, 16, 16'hBEEF, 0, 64'h88, -1);
        vectors++;
        if (r_pass !== 1'b0 || r_err !== 7'd2 || r_first !== 6'd3) begin
            miscompares++;
            $display("FAIL corrupt_3_7: got pass=%b err=%0d first=%0d expected 0 2 3", r_pass, r_err, r_first);
        end
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 64);
            c = {$urandom, $urandom};
            if (t == 3) c = 64'h0 | (64'h1 << (n - 1));
            run_bist(23'($urandom), n, 16'($urandom), 1, c, -1);
            vectors++;
            if (r_pass !== (exp_errs(c, n) == 0) || r_err !== 7'(exp_errs(c, n)) || r_first !== 6'(exp_first(c, n))) begin
                miscompares++;
                $display("FAIL corrupt_rand[%0d]: got pass=%b err=%0d first=%0d expected %b %0d %0d", t, r_pass,
                         r_err, r_first, exp_errs(c, n) == 0, exp_errs(c, n), exp_first(c, n));
            end
        end
    endtask

    task automatic test_lengths();
        logic [6:0] lens [3] = '{7'd0, 7'd65, 7'd127};
        for (int t = 0; t < 3; t++) begin
            @(negedge clk_core);
            num_words = lens[t]; seed = 16'($urandom); start = 1'b1;
            @(negedge clk_core);
            start = 1'b0;
            vectors++;
            if (done !== 1'b1 || pass !== (t == 0) || bad_len !== (t != 0) || busy !== 1'b0 ||
                err_count !== 7'd0 || wr_valid !== 1'b0 || cmd_valid !== 1'b0 || rd_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL len_%0d: got done=%b pass=%b bad_len=%b busy=%b wv=%b cv=%b expected 1 %b %b 0 0 0",
                         lens[t], done, pass, bad_len, busy, wr_valid, cmd_valid, t == 0, t != 0);
            end
            @(negedge clk_core);
            vectors++;
            if (done !== 1'b0 || wr_valid !== 1'b0 || cmd_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL len_%0d_after: got done=%b wv=%b cv=%b expected 0 0 0", lens[t], done, wr_valid, cmd_valid);
            end
        end
    endtask

    task automatic test_stall();
        run_bist(23'h7FFF00, 64, 16'($urandom), 1, 64'h0, -1);
        vectors++;
        if (r_pass !== 1'b1 || r_err !== 7'd0 || r_wr != 64 || r_rd != 64 || bad_len !== 1'b0) begin
            miscompares++;
            $display("FAIL stall64: got pass=%b err=%0d wr=%0d rd=%0d bad_len=%b expected 1 0 64 64 0",
                     r_pass, r_err, r_wr, r_rd, bad_len);
        end
        run_bist(23'h000040, 5, 16'h0000, 1, 64'h0, -1);
        vectors++;
        if (r_pass !== 1'b1 || r_wr != 5) begin
            miscompares++;
            $display("FAIL zero_seed: got pass=%b wr=%0d expected 1 5", r_pass, r_wr);
        end
    endtask

    task automatic test_start_during_done();
        run_bist(23'h000200, 8, 16'h5A5A, 0, 64'h0, -1);
        start = 1'b1; num_words = 7'd5;
        @(negedge clk_core);
        start = 1'b0;
        repeat (2) @(negedge clk_core);
        vectors++;
        if (busy !== 1'b0 || wr_valid !== 1'b0 || pass !== 1'b1) begin
            miscompares++;
            $display("FAIL start_on_done: got busy=%b wv=%b pass=%b expected 0 0 1", busy, wr_valid, pass);
        end
    endtask

    task automatic test_reset_mid();
        run_bist(23'h000300, 32, 16'($urandom), 1, 64'h0, 10);
        run_bist(23'h000300, 12, 16'($urandom), 0, 64'h0, -1);
        vectors++;
        if (r_pass !== 1'b1 || r_rd != 12) begin
            miscompares++;
            $display("FAIL after_reset: got pass=%b rd=%0d expected 1 12", r_pass, r_rd);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; seed = '0;
        cmd_ready = 1'b0; wr_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_corrupt();
        test_lengths();
        test_stall();
        test_start_during_done();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cellram_bist.md
Name: cellram_bist

Overview:
- Synthesizable self-test initiator for the cellram_interface user port (cmd/wr/rd streams).
- On start it:
  - pushes an LFSR-generated burst into the write stream;
  - issues INSTR_WRITE, then INSTR_READ, to the same address;
  - reads the burst back and compares it against a regenerated pattern;
  - reports pass/fail, error count and the first failing word index.
- Sits beside the application logic in the clk_core domain; used for power-on memory check and board bring-up.

Parameters:
- Nb, 16: data word width.
- Nb_addr, 23: memory word address width.
- Nb_bl, 6: burst-length field width; the maximum burst is 2^Nb_bl = 64 words.
- Nb_inst, 3: command instruction width.

Ports:
- clk_core  in  1  core clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle start request; ignored while busy.
- base_addr  in  Nb_addr  burst start address; sampled at start.
- num_words  in  Nb_bl+1  burst length, 1..64; sampled at start.
- seed  in  Nb  LFSR seed; sampled at start.
- busy  out  1  test in progress.
- done  out  1  one-cycle completion pulse.
- pass  out  1  result of the last test; valid from done until the next start.
- bad_len  out  1  last request was rejected for an illegal length.
- err_count  out  Nb_bl+1  number of mismatching words in the last test.
- first_err  out  Nb_bl  index of the first mismatching word; 0 if none.
- cmd_bl  out  Nb_bl  num_words-1.
- cmd_instr  out  Nb_inst  instruction.
- cmd_addr  out  Nb_addr  command address.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  command accepted.
- wr_data  out  Nb  write word.
- wr_valid  out  1  write word valid.
- wr_ready  in  1  write word accepted.
- rd_data  in  Nb  read word.
- rd_valid  in  1  read word valid.
- rd_ready  out  1  bist accepts a read word.

Behaviour:
- Handshakes:
  - A transfer occurs at a rising edge where valid and ready are both high.
  - Once valid is raised, it and its payload stay stable until the transfer.
  - cmd_count, wr_count and rd_count are not used.
- Reset values: busy, done, pass, bad_len, cmd_valid, wr_valid, rd_ready = 0; err_count, first_err, cmd_* and wr_data = 0; FSM in IDLE.
- Constants: INSTR_WRITE = 3'b000, INSTR_READ = 3'b001.
- LFSR:
  - 16-bit Galois, right-shift, mask 16'hB400.
  - A seed of 0 is replaced by 16'hACE1.
  - The write LFSR advances only on an accepted wr transfer.
  - The compare LFSR is reloaded from the latched seed and advances only on an accepted rd transfer.
- FSM states:
  - IDLE: waits for start.
    - num_words == 0: done pulses the next cycle with pass=1, no bus activity.
    - num_words > 64: done pulses with pass=0, bad_len=1, no bus activity.
    - Otherwise: latch inputs, clear err_count, first_err and bad_len, set busy, go to WR_DATA.
  - WR_DATA: wr_valid=1 with wr_data = LFSR state. After num_words accepted words, go to WR_CMD. All data precedes the write command.
  - WR_CMD: cmd_valid=1, cmd_instr=INSTR_WRITE, cmd_addr=base_addr, cmd_bl=num_words-1. On accept, go to RD_CMD.
  - RD_CMD: same fields with INSTR_READ. On accept, go to RD_DATA.
  - RD_DATA: rd_ready=1 continuously.
    - Each accepted word is compared with the compare LFSR.
    - On mismatch, err_count increments; first_err latches the index on the first mismatch.
    - After num_words words, go to DONE.
  - DONE: clear busy and pulse done for one cycle; pass = (err_count==0); return to IDLE.
- Results hold until the next accepted start.
- The word counter is Nb_bl+1 bits; err_count cannot exceed 64, so no saturation logic is needed.
- Reset mid-test: immediate return to reset values, with no further transfers. reset must be the same net as cellram_interface reset, so that its FIFOs are flushed together with the bist.
- A start pulse coinciding with done: ignored, because busy is still asserted that cycle.

Optional Feature:
- CELLRAM_BIST_TIMEOUT_EN defined:
  - A 16-bit watchdog counts cycles spent in any non-IDLE state without a handshake.
  - At 16'hFFFF it forces DONE with pass=0 and sets an extra output port timeout=1 (cleared on next start).
  - All valid/ready outputs drop that cycle.
- Undefined: no watchdog and no timeout port; a stalled interface keeps busy high indefinitely.

Decomposition:
- Package cellram_pkg: Nb, Nb_addr, Nb_bl, Nb_inst, INSTR_WRITE, INSTR_READ, LFSR mask, zero-seed substitute.
- Sub-module cellram_bist_lfsr: load/advance enables plus state output; instantiated twice (write and compare).

Test Plan:
- Against cellram_interface plus the cellram model: seed=16'h1234, base_addr=0, num_words=1 -> one wr, two cmds, one rd; done, pass=1, err_count=0.
- Run back-to-back tests at 0/16, 23'h00A0F2/22, 23'h001607/35, 23'h00A0F5/19 (overlapping regions) -> each pass=1. Second run at 0 must not read stale data.
- Stub responder inverts rd_data bit 0 on words 3 and 7 of a 16-word burst -> pass=0, err_count=2, first_err=3.
- num_words=0 -> done after 1 cycle, pass=1, no valid asserted. num_words=65 -> pass=0, bad_len=1.
- Random wr_ready/cmd_ready/rd_valid stalls (50%) with 64 words -> payload stable while valid, pass=1. Assert reset mid-RD_DATA -> all outputs return to reset values in the same cycle.
- With CELLRAM_BIST_TIMEOUT_EN defined and cmd_ready tied 0 -> done after 65536 stalled cycles, pass=0, timeout=1.
